tdm_demux: RTL and testbench

- Receive end of the team's time-division channel mux: takes one shared data lane that carries NUM_CH channels interleaved slot-by-slot, and redistributes each slot into a registered per-channel output with a valid strobe.
- Slot 0 of each frame is marked by a sync pulse. The block aligns to it, tracks slots with a counter, and flags alignment errors.
- Sits directly downstream of the channel mux, on the same clock.

---
 rtl/tdm_demux.sv | 82 ++++++++
 tb/tb_tdm_demux.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/tdm_demux.sv
// Receive side of the TDM channel mux: aligns to the slot-0 sync marker and
// scatters each slot sample of the shared lane into its own registered channel.
module tdm_demux #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     sync,
  input  logic [DATA_W-1:0]        din,
  output logic [NUM_CH*DATA_W-1:0] dout,
  output logic [NUM_CH-1:0]        dvalid,
  output logic                     frame_done,
  output logic                     locked,
  output logic [CNT_W-1:0]         slot,
  output logic                     err
);

  typedef enum logic [0:0] {StHunt, StLocked} state_e;

  state_e r_state;

  localparam logic [CNT_W-1:0]  LastSlot = CNT_W'(NUM_CH - 1);
  localparam logic [NUM_CH-1:0] Ch0Bit   = NUM_CH'(1);

  assign locked = (r_state == StLocked);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StHunt;
      slot       <= '0;
      dout       <= '0;
      dvalid     <= '0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      dvalid     <= '0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      if (en) begin
        case (r_state)
          StHunt: begin
            if (sync) begin
              dout[DATA_W-1:0] <= din;
              dvalid           <= Ch0Bit;
              slot             <= CNT_W'(1);
              r_state          <= StLocked;
            end
          end
          StLocked: begin
            if (sync) begin
              // Sync always realigns to slot 0; arriving early is still an error.
              dout[DATA_W-1:0] <= din;
              dvalid           <= Ch0Bit;
              slot             <= CNT_W'(1);
              err              <= (slot != '0);
            end else if (slot == '0) begin
              err     <= 1'b1;
              slot    <= '0;
              r_state <= StHunt;
            end else begin
              for (int k = 1; k < int'(NUM_CH); k++) begin
                if (slot == CNT_W'(k)) dout[k*DATA_W +: DATA_W] <= din;
              end
              dvalid <= Ch0Bit << slot;
              if (slot == LastSlot) begin
                frame_done <= 1'b1;
                slot       <= '0;
              end else begin
                slot <= slot + CNT_W'(1);
              end
            end
          end
          default: r_state <= StHunt;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux.sv
// Directed self-checking bench for tdm_demux (NUM_CH=4, DATA_W=8).
module tb_tdm_demux;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        sync;
  logic [7:0]  din;
  logic [31:0] dout;
  logic [3:0]  dvalid;
  logic        frame_done;
  logic        locked;
  logic [1:0]  slot;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  tdm_demux #(.NUM_CH(4), .DATA_W(8), .CNT_W(2)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .sync       (sync),
    .din        (din),
    .dout       (dout),
    .dvalid     (dvalid),
    .frame_done (frame_done),
    .locked     (locked),
    .slot       (slot),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one slot, clock it in, then sample just after the edge.
  task automatic step(input logic e, input logic s, input logic [7:0] d);
    en   = e;
    sync = s;
    din  = d;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_frame;
  logic [7:0]  v;

  initial begin
    rst_n = 1'b1;
    en    = 1'b0;
    sync  = 1'b0;
    din   = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    check("rst_dout",   64'(dout),       64'h0);
    check("rst_dvalid", 64'(dvalid),     64'h0);
    check("rst_locked", 64'(locked),     64'h0);
    check("rst_slot",   64'(slot),       64'h0);
    check("rst_err",    64'(err),        64'h0);
    check("rst_fdone",  64'(frame_done), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset then lock
    step(1'b1, 1'b1, 8'h11);
    check("lock_dv0",    64'(dvalid), 64'h1);
    check("lock_locked", 64'(locked), 64'h1);
    check("lock_slot1",  64'(slot),   64'h1);
    step(1'b1, 1'b0, 8'h22);
    check("lock_dv1", 64'(dvalid), 64'h2);
    step(1'b1, 1'b0, 8'h33);
    check("lock_dv2",    64'(dvalid),     64'h4);
    check("lock_nofd",   64'(frame_done), 64'h0);
    step(1'b1, 1'b0, 8'h44);
    check("lock_dv3",   64'(dvalid),     64'h8);
    check("lock_fdone", 64'(frame_done), 64'h1);
    check("lock_dout",  64'(dout),       64'h44332211);
    check("lock_wrap",  64'(slot),       64'h0);

    // Gapped enable; sync during the gap must be ignored too
    step(1'b1, 1'b1, 8'h11);
    step(1'b1, 1'b0, 8'h22);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 8'hFF);
      check("gap_dvalid", 64'(dvalid), 64'h0);
      check("gap_slot",   64'(slot),   64'h2);
      check("gap_err",    64'(err),    64'h0);
      check("gap_dout",   64'(dout),   64'h44332211);
    end
    step(1'b1, 1'b0, 8'h33);
    check("gap_dv2", 64'(dvalid), 64'h4);
    step(1'b1, 1'b0, 8'h44);
    check("gap_fdone", 64'(frame_done), 64'h1);
    check("gap_dout2", 64'(dout),       64'h44332211);

    // Missing sync at slot 0
    step(1'b1, 1'b0, 8'h55);
    check("miss_err",    64'(err),    64'h1);
    check("miss_locked", 64'(locked), 64'h0);
    check("miss_dvalid", 64'(dvalid), 64'h0);
    check("miss_slot",   64'(slot),   64'h0);
    check("miss_dout",   64'(dout),   64'h44332211);
    step(1'b1, 1'b0, 8'h66);
    check("hunt_err",    64'(err),    64'h0);
    check("hunt_dvalid", 64'(dvalid), 64'h0);
    check("hunt_dout",   64'(dout),   64'h44332211);
    check("hunt_locked", 64'(locked), 64'h0);

    // Relock, then early sync at slot 2
    step(1'b1, 1'b1, 8'h11);
    check("relock", 64'(locked), 64'h1);
    step(1'b1, 1'b0, 8'hAA);
    check("early_pre_slot", 64'(slot), 64'h2);
    step(1'b1, 1'b1, 8'h99);
    check("early_err",    64'(err),        64'h1);
    check("early_dvalid", 64'(dvalid),     64'h1);
    check("early_slot",   64'(slot),       64'h1);
    check("early_locked", 64'(locked),     64'h1);
    check("early_nofd",   64'(frame_done), 64'h0);
    check("early_dout",   64'(dout),       64'h4433AA99);
    step(1'b1, 1'b0, 8'hBB);
    check("early_next_err", 64'(err),  64'h0);
    check("early_next_dv",  64'(dvalid), 64'h2);

    // Asynchronous reset mid-frame (slot 2), away from any edge
    check("mid_slot_pre", 64'(slot), 64'h2);
    #3 rst_n = 1'b0;
    #1;
    check("mid_dout",   64'(dout),   64'h0);
    check("mid_dvalid", 64'(dvalid), 64'h0);
    check("mid_locked", 64'(locked), 64'h0);
    check("mid_slot",   64'(slot),   64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 8'h77);
    check("post_hunt_dv",   64'(dvalid), 64'h0);
    check("post_hunt_dout", 64'(dout),   64'h0);
    check("post_hunt_lock", 64'(locked), 64'h0);
    check("post_hunt_err",  64'(err),    64'h0);

    // Three back-to-back frames
    for (int f = 0; f < 3; f++) begin
      exp_frame = '0;
      for (int k = 0; k < 4; k++) begin
        v = 8'(8'hA0 + 8'(f * 16) + 8'(k));
        exp_frame[k*8 +: 8] = v;
        step(1'b1, (k == 0), v);
        check("b2b_err",   64'(err),        64'h0);
        check("b2b_fdone", 64'(frame_done), 64'((k == 3) ? 1 : 0));
        check("b2b_dv",    64'(dvalid),     64'(4'b0001 << k));
      end
      check("b2b_dout", 64'(dout), 64'(exp_frame));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
